// File: rtl/mersenne_modexp_pkg.sv
// Shared types and defaults for the Mersenne-factor modular exponentiator.
// Holds the FSM state encoding and the default widths. The external divider
// is sized DIV_BITWIDTH = 2*WIDTH so the full square of R fits without truncation.
package mersenne_pkg;

    localparam int DEF_WIDTH    = 32;
    localparam int DEF_EXPW     = 32;
    localparam int DIV_BITWIDTH = 2 * DEF_WIDTH;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SCAN,
        S_SQUARE,
        S_ARM,
        S_WAIT,
        S_DOUBLE,
        S_NEXT,
        S_DONE
    } state_e;

endpackage

// File: rtl/mersenne_modexp_if.sv
// Bundled ports of the exponentiator.
// mersenne_modexp_if: request/result handshake to the candidate generator and
//   result collector (master = generator side, slave = exponentiator).
// mersenne_div_if: start/finished handshake to the external modulo divider
//   (master = exponentiator, slave = divider).
interface mersenne_modexp_if
    import mersenne_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int EXPW  = DEF_EXPW
);
    logic             start;
    logic [EXPW-1:0]  exponent;
    logic [WIDTH-1:0] modulus;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             is_factor;
    logic             err;
    logic             filtered;

    modport master (output start, exponent, modulus,
                    input  busy, done, result, is_factor, err, filtered);
    modport slave  (input  start, exponent, modulus,
                    output busy, done, result, is_factor, err, filtered);
endinterface

interface mersenne_div_if
    import mersenne_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);
    localparam int DW = 2 * WIDTH;

    logic          div_start;
    logic [DW-1:0] div_numerator;
    logic [DW-1:0] div_denominator;
    logic [DW-1:0] div_remainder;
    logic          div_finished;

    modport master (output div_start, div_numerator, div_denominator,
                    input  div_remainder, div_finished);
    modport slave  (input  div_start, div_numerator, div_denominator,
                    output div_remainder, div_finished);
endinterface

// File: rtl/mersenne_modexp_double.sv
// mod_double: combinational modular doubling, o_r = (2R >= Q) ? 2R-Q : 2R.
// Requires R < Q, so a single conditional subtract gives a fully reduced value.
module mod_double
    import mersenne_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] i_r,
    input  logic [WIDTH-1:0] i_q,
    output logic [WIDTH-1:0] o_r
);
    // 2R needs one extra bit; the compare uses it, the subtract result fits WIDTH.
    logic [WIDTH:0] w_t;
    logic [WIDTH:0] w_q_ext;

    assign w_t     = {i_r, 1'b0};
    assign w_q_ext = {1'b0, i_q};
    assign o_r     = (w_t >= w_q_ext) ? (w_t[WIDTH-1:0] - i_q) : w_t[WIDTH-1:0];
endmodule

// File: rtl/mersenne_modexp.sv
// mersenne_modexp: computes R = 2^P mod Q by left-to-right binary exponentiation
// and flags Q as a factor of 2^P-1 when R == 1. Each exponent bit squares R and
// reduces the 2*WIDTH product through the external divider (mersenne_div_if);
// set bits additionally double-and-reduce R through mod_double.
// Optional feature macro: MODEXP_PREFILTER_EN rejects moduli whose low three
// bits are not 3'b001 or 3'b111 without running the exponentiation.
module mersenne_modexp
    import mersenne_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int EXPW  = DEF_EXPW
) (
    input  logic                    sys_clk,
    input  logic                    sys_rst_n,
    mersenne_modexp_if.slave        host,
    mersenne_div_if.master          div
);
    localparam int DIVW = 2 * WIDTH;
    localparam int IDXW = (EXPW > 1) ? $clog2(EXPW) : 1;
    localparam logic [IDXW-1:0] IDX_TOP = IDXW'(EXPW - 1);

    state_e            r_state;
    state_e            w_state_next;
    logic [EXPW-1:0]   r_p;
    logic [WIDTH-1:0]  r_q;
    logic [WIDTH-1:0]  r_r;
    logic [IDXW-1:0]   r_idx;
    logic [DIVW-1:0]   r_num;
    logic              r_busy;
    logic              r_done;
    logic              r_div_start;
    logic [WIDTH-1:0]  r_result;
    logic              r_is_factor;
    logic              r_err;
    logic              r_filtered;

    logic              w_accept;
    logic              w_q_zero;
    logic              w_q_one;
    logic              w_p_zero;
    logic              w_reject;
    logic              w_bit;
    logic [WIDTH-1:0]  w_r_init;
    logic [WIDTH-1:0]  w_dbl;
    logic [WIDTH-1:0]  w_rem;
    logic [DIVW-1:0]   w_square;
    logic              w_unused_rem_hi;

    assign w_accept = (r_state == S_IDLE) && host.start && !r_busy;
    assign w_q_zero = (host.modulus == '0);
    assign w_q_one  = (host.modulus == WIDTH'(1));
    assign w_p_zero = (host.exponent == '0);
    assign w_r_init = w_q_one ? '0 : WIDTH'(1);
    assign w_bit    = r_p[r_idx];
    assign w_square = DIVW'(r_r) * DIVW'(r_r);
    assign w_rem    = div.div_remainder[WIDTH-1:0];
    // R < Q always, so the divider's upper remainder half is zero by construction.
    assign w_unused_rem_hi = |div.div_remainder[DIVW-1:WIDTH];

`ifdef MODEXP_PREFILTER_EN
    // Factors of 2^P-1 (P prime) are 1 or 7 mod 8; anything else cannot divide.
    assign w_reject = (host.modulus[2:0] != 3'b001) && (host.modulus[2:0] != 3'b111);
`else
    assign w_reject = 1'b0;
`endif

    mod_double #(.WIDTH(WIDTH)) u_mod_double (
        .i_r (r_r),
        .i_q (r_q),
        .o_r (w_dbl)
    );

    assign host.busy       = r_busy;
    assign host.done       = r_done;
    assign host.result     = r_result;
    assign host.is_factor  = r_is_factor;
    assign host.err        = r_err;
    assign host.filtered   = r_filtered;
    // div_start is registered so it is high in the same cycle the registered numerator is valid.
    assign div.div_start       = r_div_start;
    assign div.div_numerator   = r_num;
    assign div.div_denominator = {{WIDTH{1'b0}}, r_q};

    // State register.
    always_ff @(posedge sys_clk) begin
        // NOTE: sequential state uses <= only, so every flop sees pre-edge values.
        if (!sys_rst_n) r_state <= S_IDLE;
        else            r_state <= w_state_next;
    end

    // Next-state decode; latency per bit is set by div_finished, never by a cycle count.
    always_comb begin
        // NOTE: default assigned first so no path leaves w_state_next unassigned (no latch).
        w_state_next = r_state;
        case (r_state)
            S_IDLE:   if (w_accept) w_state_next = (w_q_zero || w_reject || w_p_zero) ? S_DONE : S_SCAN;
            S_SCAN:   if (w_bit) w_state_next = S_SQUARE;
            S_SQUARE: w_state_next = S_ARM;
            S_ARM:    w_state_next = S_WAIT;
            S_WAIT:   if (div.div_finished) w_state_next = w_bit ? S_DOUBLE : S_NEXT;
            S_DOUBLE: w_state_next = S_NEXT;
            S_NEXT:   w_state_next = (r_idx == '0) ? S_DONE : S_SQUARE;
            S_DONE:   w_state_next = S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase
    end

    // Datapath and result registers; done is raised on entry to S_DONE so results are valid with it.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_div_start <= 1'b0;
            r_result    <= '0;
            r_is_factor <= 1'b0;
            r_err       <= 1'b0;
            r_filtered  <= 1'b0;
            r_p         <= '0;
            r_q         <= '0;
            r_r         <= '0;
            r_idx       <= '0;
            r_num       <= '0;
        end else begin
            r_done      <= 1'b0;
            r_div_start <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_p        <= host.exponent;
                        r_q        <= host.modulus;
                        r_idx      <= IDX_TOP;
                        r_r        <= w_r_init;
                        r_busy     <= 1'b1;
                        r_err      <= 1'b0;
                        r_filtered <= 1'b0;
                        if (w_q_zero) begin
                            r_err       <= 1'b1;
                            r_result    <= w_r_init;
                            r_is_factor <= 1'b0;
                            r_done      <= 1'b1;
                        end else if (w_reject) begin
                            r_filtered  <= 1'b1;
                            r_result    <= '0;
                            r_is_factor <= 1'b0;
                            r_done      <= 1'b1;
                        end else if (w_p_zero) begin
                            r_result    <= w_r_init;
                            r_is_factor <= (w_r_init == WIDTH'(1));
                            r_done      <= 1'b1;
                        end
                    end
                end
                S_SCAN:   if (!w_bit) r_idx <= r_idx - IDXW'(1);
                S_SQUARE: begin
                    r_num       <= w_square;
                    r_div_start <= 1'b1;
                end
                S_WAIT:   if (div.div_finished) r_r <= w_rem;
                S_DOUBLE: r_r <= w_dbl;
                S_NEXT: begin
                    if (r_idx == '0) begin
                        r_result    <= r_r;
                        r_is_factor <= (r_r == WIDTH'(1));
                        r_done      <= 1'b1;
                    end else begin
                        r_idx <= r_idx - IDXW'(1);
                    end
                end
                S_DONE:   r_busy <= 1'b0;
                default:  ;
            endcase
        end
    end
endmodule

// File: tb/tb_mersenne_modexp.sv
// Directed testbench for mersenne_modexp with a behavioural variable-latency divider.
// Honours MODEXP_PREFILTER_EN so the same bench covers both builds.
module tb_mersenne_modexp;
    import mersenne_pkg::*;

    localparam int LIMIT = 3000;

    logic sys_clk = 1'b0;
    logic sys_rst_n;
    int   checks = 0;
    int   errors = 0;
    int   div_starts = 0;

    mersenne_modexp_if host_if ();
    mersenne_div_if    div_if ();

    mersenne_modexp dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .host      (host_if),
        .div       (div_if)
    );

    always #5 sys_clk = ~sys_clk;

    // Behavioural divider: drops finished on start, answers 1..4 cycles later.
    // Deliberately not reset by sys_rst_n: a new div_start must reinitialise it.
    logic [63:0] m_num = '0;
    logic [63:0] m_den = 64'd1;
    logic [63:0] m_rem = '0;
    logic        m_fin = 1'b1;
    int          m_cnt = 0;

    assign div_if.div_remainder = m_rem;
    assign div_if.div_finished  = m_fin;

    always @(posedge sys_clk) begin
        if (div_if.div_start === 1'b1) begin
            m_num      <= div_if.div_numerator;
            m_den      <= div_if.div_denominator;
            m_fin      <= 1'b0;
            m_cnt      <= 1 + (div_starts % 4);
            div_starts <= div_starts + 1;
        end else if (!m_fin) begin
            if (m_cnt <= 1) begin
                m_rem <= m_num % m_den;
                m_fin <= 1'b1;
            end else begin
                m_cnt <= m_cnt - 1;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic run_op(input logic [31:0] p, input logic [31:0] q,
                          output logic [31:0] res, output logic isf, output logic er,
                          output logic flt, output int cyc, output int nst);
        int base;
        @(negedge sys_clk);
        host_if.exponent = p;
        host_if.modulus  = q;
        host_if.start    = 1'b1;
        base             = div_starts;
        @(negedge sys_clk);
        host_if.start = 1'b0;
        cyc = 0;
        while (host_if.done !== 1'b1 && cyc < LIMIT) begin
            @(negedge sys_clk);
            cyc++;
        end
        checks++;
        if (host_if.done !== 1'b1) begin
            errors++;
            $display("FAIL done_timeout p=%0d q=%0d got done=%b want 1", p, q, host_if.done);
        end
        res = host_if.result;
        isf = host_if.is_factor;
        er  = host_if.err;
        flt = host_if.filtered;
        nst = div_starts - base;
    endtask

    task automatic test_reset();
        sys_rst_n = 1'b0;
        repeat (3) @(negedge sys_clk);
        checks++; if (host_if.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", host_if.busy); end
        checks++; if (host_if.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", host_if.done); end
        checks++; if (div_if.div_start !== 1'b0) begin errors++; $display("FAIL reset_div_start got %b want 0", div_if.div_start); end
        checks++; if (host_if.result !== 32'd0) begin errors++; $display("FAIL reset_result got %0d want 0", host_if.result); end
        checks++; if ({host_if.is_factor, host_if.err, host_if.filtered} !== 3'b000) begin
            errors++; $display("FAIL reset_flags got %b want 000", {host_if.is_factor, host_if.err, host_if.filtered});
        end
        sys_rst_n = 1'b1;
        @(negedge sys_clk);
    endtask

    task automatic test_compute();
        logic [31:0] res; logic isf, er, flt; int cyc, nst;
        run_op(32'd11, 32'd23, res, isf, er, flt, cyc, nst);
        checks++; if (res !== 32'd1) begin errors++; $display("FAIL p11q23_result got %0d want 1", res); end
        checks++; if ({isf, er, flt} !== 3'b100) begin errors++; $display("FAIL p11q23_flags got %b want 100", {isf, er, flt}); end
        checks++; if (nst !== 4) begin errors++; $display("FAIL p11q23_div_starts got %0d want 4", nst); end
        checks++; if (host_if.busy !== 1'b1) begin errors++; $display("FAIL p11q23_busy_at_done got %b want 1", host_if.busy); end
        @(negedge sys_clk);
        checks++; if ({host_if.busy, host_if.done} !== 2'b00) begin
            errors++; $display("FAIL p11q23_after_done busy,done got %b want 00", {host_if.busy, host_if.done});
        end
        run_op(32'd11, 32'd47, res, isf, er, flt, cyc, nst);
        checks++; if (res !== 32'd27) begin errors++; $display("FAIL p11q47_result got %0d want 27", res); end
        checks++; if (isf !== 1'b0) begin errors++; $display("FAIL p11q47_is_factor got %b want 0", isf); end
        run_op(32'd23, 32'd47, res, isf, er, flt, cyc, nst);
        checks++; if (res !== 32'd1) begin errors++; $display("FAIL p23q47_result got %0d want 1", res); end
        checks++; if (isf !== 1'b1) begin errors++; $display("FAIL p23q47_is_factor got %b want 1", isf); end
        checks++; if (nst !== 5) begin errors++; $display("FAIL p23q47_div_starts got %0d want 5", nst); end
    endtask

    task automatic test_edge_cases();
        logic [31:0] res; logic isf, er, flt; int cyc, nst;
        run_op(32'd0, 32'd7, res, isf, er, flt, cyc, nst);
        checks++; if (res !== 32'd1 || isf !== 1'b1) begin errors++; $display("FAIL p0q7 got res=%0d isf=%b want res=1 isf=1", res, isf); end
        checks++; if (nst !== 0) begin errors++; $display("FAIL p0q7_div_starts got %0d want 0", nst); end
        run_op(32'd5, 32'd1, res, isf, er, flt, cyc, nst);
        checks++; if (res !== 32'd0 || isf !== 1'b0) begin errors++; $display("FAIL p5q1 got res=%0d isf=%b want res=0 isf=0", res, isf); end
        run_op(32'd11, 32'd0, res, isf, er, flt, cyc, nst);
        checks++; if (er !== 1'b1 || isf !== 1'b0) begin errors++; $display("FAIL q0 got err=%b isf=%b want err=1 isf=0", er, isf); end
        checks++; if (nst !== 0) begin errors++; $display("FAIL q0_div_starts got %0d want 0", nst); end
        run_op(32'd11, 32'd23, res, isf, er, flt, cyc, nst);
        checks++; if (er !== 1'b0) begin errors++; $display("FAIL err_cleared got %b want 0", er); end
    endtask

    task automatic test_busy_ignore();
        int cyc, base;
        @(negedge sys_clk);
        host_if.exponent = 32'd11; host_if.modulus = 32'd47; host_if.start = 1'b1;
        base = div_starts;
        @(negedge sys_clk);
        host_if.start = 1'b0;
        repeat (3) @(negedge sys_clk);
        host_if.exponent = 32'd0; host_if.modulus = 32'd7; host_if.start = 1'b1;
        @(negedge sys_clk);
        host_if.start = 1'b0;
        checks++; if (host_if.busy !== 1'b1) begin errors++; $display("FAIL busy_during_op got %b want 1", host_if.busy); end
        cyc = 0;
        while (host_if.done !== 1'b1 && cyc < LIMIT) begin @(negedge sys_clk); cyc++; end
        checks++; if (host_if.result !== 32'd27) begin errors++; $display("FAIL ignored_start_result got %0d want 27", host_if.result); end
        checks++; if (div_starts - base !== 4) begin errors++; $display("FAIL ignored_start_div_starts got %0d want 4", div_starts - base); end
        // Start coincident with the done cycle must be dropped.
        host_if.exponent = 32'd0; host_if.modulus = 32'd7; host_if.start = 1'b1;
        @(negedge sys_clk);
        host_if.start = 1'b0;
        checks++; if ({host_if.busy, host_if.done} !== 2'b00) begin
            errors++; $display("FAIL start_on_done busy,done got %b want 00", {host_if.busy, host_if.done});
        end
        repeat (3) @(negedge sys_clk);
        checks++; if (host_if.result !== 32'd27 || host_if.done !== 1'b0) begin
            errors++; $display("FAIL result_held got res=%0d done=%b want res=27 done=0", host_if.result, host_if.done);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] res; logic isf, er, flt; int cyc, nst;
        @(negedge sys_clk);
        host_if.exponent = 32'd23; host_if.modulus = 32'd47; host_if.start = 1'b1;
        @(negedge sys_clk);
        host_if.start = 1'b0;
        cyc = 0;
        while (div_if.div_start !== 1'b1 && cyc < LIMIT) begin @(negedge sys_clk); cyc++; end
        checks++; if (div_if.div_start !== 1'b1) begin errors++; $display("FAIL mid_div_start_timeout got %b want 1", div_if.div_start); end
        @(negedge sys_clk);
        sys_rst_n = 1'b0;
        @(negedge sys_clk);
        checks++; if ({host_if.busy, host_if.done, div_if.div_start} !== 3'b000) begin
            errors++; $display("FAIL mid_reset_ctrl got %b want 000", {host_if.busy, host_if.done, div_if.div_start});
        end
        checks++; if (host_if.result !== 32'd0) begin errors++; $display("FAIL mid_reset_result got %0d want 0", host_if.result); end
        sys_rst_n = 1'b1;
        run_op(32'd11, 32'd23, res, isf, er, flt, cyc, nst);
        checks++; if (res !== 32'd1 || isf !== 1'b1) begin errors++; $display("FAIL after_reset got res=%0d isf=%b want res=1 isf=1", res, isf); end
        checks++; if (nst !== 4) begin errors++; $display("FAIL after_reset_div_starts got %0d want 4", nst); end
    endtask

    task automatic test_prefilter();
        logic [31:0] res; logic isf, er, flt; int cyc, nst;
        run_op(32'd11, 32'd13, res, isf, er, flt, cyc, nst);
`ifdef MODEXP_PREFILTER_EN
        checks++; if (flt !== 1'b1 || isf !== 1'b0 || res !== 32'd0) begin
            errors++; $display("FAIL q13_filtered got flt=%b isf=%b res=%0d want 1 0 0", flt, isf, res);
        end
        checks++; if (nst !== 0 || cyc > 1) begin errors++; $display("FAIL q13_fast got starts=%0d cyc=%0d want 0 <=1", nst, cyc); end
`else
        checks++; if (flt !== 1'b0 || res !== 32'd7 || isf !== 1'b0) begin
            errors++; $display("FAIL q13_computed got flt=%b res=%0d isf=%b want 0 7 0", flt, res, isf);
        end
        checks++; if (nst !== 4) begin errors++; $display("FAIL q13_div_starts got %0d want 4", nst); end
`endif
        run_op(32'd11, 32'd23, res, isf, er, flt, cyc, nst);
        checks++; if (flt !== 1'b0 || res !== 32'd1 || isf !== 1'b1) begin
            errors++; $display("FAIL q23_pass got flt=%b res=%0d isf=%b want 0 1 1", flt, res, isf);
        end
    endtask

    initial begin
        host_if.start    = 1'b0;
        host_if.exponent = '0;
        host_if.modulus  = '0;
        sys_rst_n        = 1'b0;
        test_reset();
        test_compute();
        test_edge_cases();
        test_busy_ignore();
        test_reset_mid();
        test_prefilter();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
